// File: rtl/usb_tx_pkg.sv
// Shared definitions for the full-speed USB transmit serializer: FSM states,
// protocol constants and the {dp, dm} line-state encodings.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam int         STUFF_LIMIT  = 6;
    localparam int         EOP_SE0_BITS = 2;

    // Line states packed as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [1:0] nrzi_line(input logic level_j);
        return level_j ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI level register plus bit-stuff run counter. The level is 1 for J and 0
// for K. Stall requests one inserted 0 bit on the next advance.
module usb_nrzi_stuffer
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic adv,
    input  logic bit_in,
    input  logic clr,
    output logic level,
    output logic stall
);

    localparam logic [2:0] STUFF_MAX = 3'(STUFF_LIMIT);

    logic [2:0] ones_cnt;

    assign stall = (ones_cnt == STUFF_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level    <= 1'b1;
            ones_cnt <= '0;
        end else if (clr) begin
            level    <= 1'b1;
            ones_cnt <= '0;
        end else if (adv) begin
            // A stuffed bit is a 0, so it toggles just like a data 0
            if (stall || !bit_in) begin
                level    <= ~level;
                ones_cnt <= '0;
            end else begin
                ones_cnt <= ones_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_serializer.sv
// Full-speed USB transmit serializer: one-byte holding buffer, SYNC, LSB-first
// NRZI data with bit stuffing, and SE0/SE0/J end-of-packet.
module usb_tx_serializer
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp_out,
    output logic       dm_out,
    output logic       oe_out,
    output logic       busy,
    output logic       tx_underrun
);

    localparam logic [1:0] EOP_LAST = 2'(EOP_SE0_BITS - 1);

    tx_state_e  state, state_nxt;
    logic [7:0] hold_data, hold_data_nxt;
    logic       hold_full, hold_full_nxt;
    logic       hold_last, hold_last_nxt;
    logic       pkt_closed, pkt_closed_nxt;
    logic [7:0] sh_data, sh_data_nxt;
    logic [3:0] sh_cnt, sh_cnt_nxt;
    logic       sh_last, sh_last_nxt;
    logic [1:0] eop_cnt, eop_cnt_nxt;
    logic       line_active, line_active_nxt;
    logic       ready_q, ready_nxt;
    logic       underrun_q, underrun_nxt;

    logic       st_adv, st_bit, st_clr;
    logic       nrzi_level, stuff_stall;
    logic       accept;
    logic [1:0] line;

    usb_nrzi_stuffer u_stuffer (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (st_adv),
        .bit_in (st_bit),
        .clr    (st_clr),
        .level  (nrzi_level),
        .stall  (stuff_stall)
    );

    assign accept = tx_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            hold_last   <= 1'b0;
            pkt_closed  <= 1'b0;
            sh_data     <= '0;
            sh_cnt      <= '0;
            sh_last     <= 1'b0;
            eop_cnt     <= '0;
            line_active <= 1'b0;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_data   <= hold_data_nxt;
            hold_full   <= hold_full_nxt;
            hold_last   <= hold_last_nxt;
            pkt_closed  <= pkt_closed_nxt;
            sh_data     <= sh_data_nxt;
            sh_cnt      <= sh_cnt_nxt;
            sh_last     <= sh_last_nxt;
            eop_cnt     <= eop_cnt_nxt;
            line_active <= line_active_nxt;
            ready_q     <= ready_nxt;
            underrun_q  <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        hold_data_nxt   = hold_data;
        hold_full_nxt   = hold_full;
        hold_last_nxt   = hold_last;
        pkt_closed_nxt  = pkt_closed;
        sh_data_nxt     = sh_data;
        sh_cnt_nxt      = sh_cnt;
        sh_last_nxt     = sh_last;
        eop_cnt_nxt     = eop_cnt;
        line_active_nxt = line_active;
        underrun_nxt    = 1'b0;
        st_adv          = 1'b0;
        st_bit          = 1'b1;
        st_clr          = 1'b0;

        if (accept) begin
            hold_data_nxt = tx_data;
            hold_full_nxt = 1'b1;
            hold_last_nxt = tx_last;
            if (tx_last) begin
                pkt_closed_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                // Arming is the only transition that does not wait for a tick
                if (accept) begin
                    state_nxt   = SYNC;
                    sh_data_nxt = SYNC_BYTE;
                    sh_cnt_nxt  = 4'd8;
                    sh_last_nxt = 1'b0;
                end
            end
            SYNC, DATA: begin
                if (bit_tick) begin
                    line_active_nxt = 1'b1;
                    if (stuff_stall) begin
                        st_adv = 1'b1;
                    end else if (sh_cnt != 4'd0) begin
                        st_adv      = 1'b1;
                        st_bit      = sh_data[0];
                        sh_data_nxt = {1'b0, sh_data[7:1]};
                        sh_cnt_nxt  = sh_cnt - 4'd1;
                    end else if (hold_full) begin
                        // Next byte's bit 0 goes out on the same tick it is loaded
                        st_adv        = 1'b1;
                        st_bit        = hold_data[0];
                        sh_data_nxt   = {1'b0, hold_data[7:1]};
                        sh_cnt_nxt    = 4'd7;
                        sh_last_nxt   = hold_last;
                        hold_full_nxt = 1'b0;
                        state_nxt     = DATA;
                    end else begin
                        st_clr         = 1'b1;
                        state_nxt      = EOP_SE0;
                        eop_cnt_nxt    = '0;
                        pkt_closed_nxt = 1'b1;
                        underrun_nxt   = !sh_last;
                    end
                end
            end
            EOP_SE0: begin
                if (bit_tick) begin
                    if (eop_cnt == EOP_LAST) begin
                        state_nxt = EOP_J;
                    end else begin
                        eop_cnt_nxt = eop_cnt + 2'd1;
                    end
                end
            end
            EOP_J: begin
                if (bit_tick) begin
                    state_nxt       = IDLE;
                    line_active_nxt = 1'b0;
                    pkt_closed_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ready_nxt = !hold_full_nxt && !pkt_closed_nxt;

    always_comb begin
        line = LINE_J;
        case (state)
            SYNC, DATA: line = nrzi_line(nrzi_level);
            EOP_SE0:    line = LINE_SE0;
            default:    line = LINE_J;
        endcase
    end

    assign dp_out      = line[1];
    assign dm_out      = line[0];
    assign oe_out      = line_active;
    assign busy        = (state != IDLE);
    assign tx_ready    = ready_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: table-driven packets, pause and reset sequences,
// and random packets checked against a bit-level reference model.
module tb_usb_tx_serializer;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic       clk;
    logic       rst_n;
    logic       bit_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       dp_out;
    logic       dm_out;
    logic       oe_out;
    logic       busy;
    logic       tx_underrun;

    int checks = 0;
    int errors = 0;

    int tick_period = 4;
    bit tick_en = 1'b0;
    int phase = 0;
    int und_cnt = 0;

    logic [1:0] cap_q[$];
    logic [1:0] exp_q[$];
    logic [7:0] pkt_q[$];

    typedef struct {
        logic [31:0] bytes;
        int          n;
        bit          last;
        int          period;
        int          exp_syms;
        int          exp_und;
    } vec_t;

    vec_t       vecs[6];
    logic [1:0] seq00[19];

    usb_tx_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_tick    (bit_tick),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .dp_out      (dp_out),
        .dm_out      (dm_out),
        .oe_out      (oe_out),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    // Clock and bit-time strobe
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bit_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                if (phase >= tick_period - 1) begin
                    bit_tick = 1'b1;
                    phase    = 0;
                end else begin
                    bit_tick = 1'b0;
                    phase++;
                end
            end else begin
                bit_tick = 1'b0;
            end
        end
    end

    // Line monitor: one symbol per bit time while the pad is driven
    initial begin
        forever begin
            @(posedge clk);
            if (bit_tick && rst_n) begin
                @(negedge clk);
                if (oe_out) cap_q.push_back({dp_out, dm_out});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_underrun) und_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time budget exceeded");
        $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: SYNC + LSB-first bytes, stuff a 0 after six 1s, NRZI, EOP
    function automatic void build_expected();
        logic [7:0] sync_v = 8'h80;
        logic [7:0] b;
        bit         raw[$];
        bit         wire_bits[$];
        int         ones = 0;
        logic [1:0] lvl = SYM_J;
        exp_q.delete();
        for (int i = 0; i < 8; i++) raw.push_back(sync_v[i]);
        foreach (pkt_q[k]) begin
            b = pkt_q[k];
            for (int i = 0; i < 8; i++) raw.push_back(b[i]);
        end
        foreach (raw[j]) begin
            wire_bits.push_back(raw[j]);
            ones = raw[j] ? ones + 1 : 0;
            if (ones == 6) begin
                wire_bits.push_back(1'b0);
                ones = 0;
            end
        end
        foreach (wire_bits[j]) begin
            if (!wire_bits[j]) lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
            exp_q.push_back(lvl);
        end
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endfunction

    task automatic compare_seq(input string tag);
        int         bad = -1;
        logic [1:0] got;
        logic [1:0] want;
        checks++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && (i >= cap_q.size() || cap_q[i] !== exp_q[i])) bad = i;
        end
        if (bad < 0 && cap_q.size() != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin
            errors++;
            got  = (bad < cap_q.size()) ? cap_q[bad] : 2'bxx;
            want = (bad < exp_q.size()) ? exp_q[bad] : 2'bxx;
            $display("FAIL %s_seq: symbol %0d got %b expected %b (%0d symbols vs %0d)",
                     tag, bad, got, want, cap_q.size(), exp_q.size());
        end
    endtask

    // Driver: hold tx_valid until the byte is taken; tx_valid stays high after
    task automatic send_byte(input logic [7:0] d, input bit last);
        int t = 0;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        while (!tx_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            timeout_fail("accept");
        end else begin
            @(negedge clk);
            check("ready_low_when_full", int'(tx_ready), 0);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (busy) timeout_fail("packet_end");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_syms(input int n);
        int t = 0;
        while (cap_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (cap_q.size() < n) timeout_fail("symbol_wait");
    endtask

    task automatic run_packet(input bit last);
        cap_q.delete();
        und_cnt = 0;
        foreach (pkt_q[i]) send_byte(pkt_q[i], last && (i == pkt_q.size() - 1));
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        wait_idle();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_line"}, int'({dp_out, dm_out, oe_out, busy}), 4'b1000);
    endtask

    initial begin
        logic [3:0] snap;
        int         se0_seen;

        vecs[0] = '{bytes: 32'h00000000, n: 1, last: 1'b1, period: 4, exp_syms: 19, exp_und: 0};
        vecs[1] = '{bytes: 32'h0000FFFF, n: 2, last: 1'b1, period: 1, exp_syms: 29, exp_und: 0};
        vecs[2] = '{bytes: 32'h0000003C, n: 1, last: 1'b0, period: 3, exp_syms: 19, exp_und: 1};
        vecs[3] = '{bytes: 32'h78563412, n: 4, last: 1'b1, period: 2, exp_syms: 43, exp_und: 0};
        vecs[4] = '{bytes: 32'h000000FC, n: 1, last: 1'b1, period: 4, exp_syms: 20, exp_und: 0};
        vecs[5] = '{bytes: 32'h0000817E, n: 2, last: 1'b1, period: 1, exp_syms: 28, exp_und: 0};
        seq00 = '{SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K,
                  SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K,
                  SYM_SE0, SYM_SE0, SYM_J};

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({dp_out, dm_out, oe_out, busy, tx_ready, tx_underrun}), 6'b100000);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", int'(tx_ready), 0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", int'(tx_ready), 1);
        @(negedge clk);
        tick_en = 1'b1;

        // Table-driven packets
        for (int v = 0; v < 6; v++) begin
            tick_period = vecs[v].period;
            pkt_q.delete();
            for (int i = 0; i < vecs[v].n; i++) pkt_q.push_back(vecs[v].bytes[8*i +: 8]);
            run_packet(vecs[v].last);
            build_expected();
            check($sformatf("vec%0d_oe_bit_times", v), cap_q.size(), vecs[v].exp_syms);
            compare_seq($sformatf("vec%0d", v));
            check($sformatf("vec%0d_underrun_pulses", v), und_cnt, vecs[v].exp_und);
            check_idle($sformatf("vec%0d", v));
            if (v == 0) begin
                for (int i = 0; i < 19; i++) begin
                    check($sformatf("zero_byte_sym%0d", i),
                          (i < cap_q.size()) ? int'(cap_q[i]) : -1, int'(seq00[i]));
                end
            end
        end

        // bit_tick held low mid-byte: line and state must not move
        tick_period = 3;
        pkt_q = '{8'h55, 8'hC3};
        fork
            run_packet(1'b1);
            begin
                wait_syms(12);
                @(posedge clk);
                tick_en = 1'b0;
                @(negedge clk);
                snap = {dp_out, dm_out, oe_out, busy};
                check("pause_active", int'(snap[1:0]), 2'b11);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("pause_hold", int'({dp_out, dm_out, oe_out, busy}), int'(snap));
                end
                tick_en = 1'b1;
            end
        join
        build_expected();
        compare_seq("pause");
        check("pause_underrun_pulses", und_cnt, 0);

        // Reset in the middle of DATA abandons the packet without EOP
        tick_period = 2;
        cap_q.delete();
        send_byte(8'h00, 1'b1);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        wait_syms(12);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", int'({dp_out, dm_out, oe_out, busy, tx_ready, tx_underrun}), 6'b100000);
        repeat (4) @(negedge clk);
        check("midreset_hold", int'({dp_out, dm_out, oe_out, busy}), 4'b1000);
        se0_seen = 0;
        foreach (cap_q[i]) if (cap_q[i] == SYM_SE0) se0_seen++;
        check("midreset_no_se0", se0_seen, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_ready_rise", int'(tx_ready), 1);
        @(negedge clk);
        pkt_q = '{8'hA5, 8'hFF};
        run_packet(1'b1);
        build_expected();
        compare_seq("after_reset");
        check_idle("after_reset");

        // Random packets against the reference model
        for (int r = 0; r < 12; r++) begin
            tick_period = $urandom_range(1, 4);
            pkt_q.delete();
            for (int i = 0; i < $urandom_range(1, 5); i++) begin
                pkt_q.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255)));
            end
            run_packet(1'b1);
            build_expected();
            compare_seq($sformatf("rand%0d", r));
            check($sformatf("rand%0d_underrun_pulses", r), und_cnt, 0);
            check_idle($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_serializer.md
USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all sequential logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port bit_tick, input, 1 bit: one-clk strobe marking one full-speed bit time (12 MHz).
REQ-004 SHALL have port tx_data, input, 8 bits: packet byte, transmitted LSB first.
REQ-005 SHALL have port tx_valid, input, 1 bit: tx_data/tx_last valid.
REQ-006 SHALL have port tx_last, input, 1 bit: current byte is the final byte of the packet.
REQ-007 SHALL have port tx_ready, output, 1 bit: byte accepted on a clk edge with tx_valid&&tx_ready.
REQ-008 SHALL have port dp_out, output, 1 bit: D+ level, to D+ output pad driver.
REQ-009 SHALL have port dm_out, output, 1 bit: D- level, to D- output pad driver.
REQ-010 SHALL have port oe_out, output, 1 bit: pad output enable, high while transmitting.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port tx_underrun, output, 1 bit: one-clk pulse on holding-buffer underrun.

Function
REQ-013 SHALL implement states IDLE, SYNC, DATA, EOP_SE0, EOP_J; transitions occur only on bit_tick clk cycles, except IDLE->SYNC arming.
REQ-014 SHALL use line states J=(dp 1, dm 0), K=(dp 0, dm 1), SE0=(0,0); IDLE drives J with oe_out=0.
REQ-015 SHALL contain a one-byte holding buffer; tx_ready=1 iff buffer empty and the packet's tx_last byte not yet accepted; tx_ready is registered.
REQ-016 SHALL start a packet when a byte is accepted in IDLE; oe_out rises with the first SYNC bit on the next bit_tick.
REQ-017 SHALL transmit SYNC as raw byte 0x80 LSB first, producing line sequence KJKJKJKK from idle J.
REQ-018 SHALL NRZI-encode: bit 0 toggles J/K, bit 1 holds the previous state.
REQ-019 SHALL bit-stuff: after six consecutive 1s, insert one 0 bit; the counter clears on any 0 or stuffed bit, spans byte boundaries, and includes SYNC's final 1.
REQ-020 SHALL reload the shift register from the holding buffer on the bit_tick after the previous byte's last bit (or its trailing stuffed bit), with no idle bit time between bytes.
REQ-021 SHALL, when the shift register empties, the holding buffer is empty and tx_last was not sent, pulse tx_underrun and enter EOP_SE0.
REQ-022 SHALL, after the tx_last byte and any trailing stuff bit, drive SE0 for 2 bit times, then J for 1 bit time with oe_out=1, then enter IDLE with oe_out=0.
REQ-023 SHALL hold all outputs and state unchanged on clk cycles with bit_tick=0.
REQ-024 SHALL accept a single byte with tx_last=1 as a complete one-byte packet.

Reset
REQ-025 SHALL, while rst_n=0, immediately force IDLE, dp_out=1, dm_out=0, oe_out=0, tx_ready=0, busy=0, tx_underrun=0, empty buffers, and a zero stuff counter.
REQ-026 SHALL abandon any packet in progress on reset without emitting EOP; tx_ready SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-027 SHALL take from shared package usb_tx_pkg: the state enum, SYNC_BYTE=8'h80, STUFF_LIMIT=6, EOP_SE0_BITS=2, and the J/K/SE0 line-state constants.
REQ-028 SHALL instantiate one sub-module, usb_nrzi_stuffer, containing the stuff counter and NRZI register; it SHALL emit a stall flag to the shifter during an inserted bit.

Verification
REQ-029 SHALL cover: byte 0x00 with tx_last -> line KJKJKJKK, JKJKJKJK, SE0, SE0, J, with oe_out high for exactly 19 bit_ticks, then IDLE.
REQ-030 SHALL cover: bytes 0xFF, 0xFF (last) -> stuffed 0 after data bits 5 and 11 (counting SYNC's trailing 1), 18 data bit times, then EOP.
REQ-031 SHALL cover: byte 0x3C (not last) with no further tx_valid -> tx_underrun pulses once after its 8th bit, followed by SE0, SE0, J, IDLE.
REQ-032 SHALL cover: bit_tick held low for 10 clks mid-byte -> dp_out, dm_out, oe_out and state stable; transmission resumes on the next tick.
REQ-033 SHALL cover: rst_n asserted mid-DATA -> same cycle oe_out=0, dp_out=1, dm_out=0, no SE0 observed; a new packet after release transmits correctly.
REQ-034 SHALL cover: tx_valid held continuously across a 4-byte packet -> tx_ready low while the buffer is full, every byte accepted exactly once, no underrun.
